// File: rtl/pipe_ex_pkg.sv
// Shared opcode, branch-subtype, ALU-code and FSM-state definitions for the pipe_ex execute stage.
package pipe_ex_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLL  = 2;
    localparam int unsigned ALU_SLT  = 3;
    localparam int unsigned ALU_SLTU = 4;
    localparam int unsigned ALU_XOR  = 5;
    localparam int unsigned ALU_SRL  = 6;
    localparam int unsigned ALU_SRA  = 7;
    localparam int unsigned ALU_OR   = 8;
    localparam int unsigned ALU_AND  = 9;
    localparam int unsigned ALU_SEQ  = 10;

    typedef enum logic [2:0] {IDLE, EXEC, SHIFT, DONE, RELEASE} ex_state_e;

    function automatic logic is_shift_op(input int unsigned code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for pipe_ex. With EX_BARREL_SHIFT_EN defined, shifts are computed here;
// otherwise shift ops pass opr1 through and the parent iterates them.
module ex_alu
    import pipe_ex_pkg::*;
#(
    parameter int REG_SZ  = 32,
    parameter int ALUOP_L = 5
) (
    input  logic [ALUOP_L-1:0] alu_op,
    input  logic [REG_SZ-1:0]  a,
    input  logic [REG_SZ-1:0]  b,
    output logic [REG_SZ-1:0]  y,
    output logic               valid
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y     = '0;
        valid = 1'b1;
        case (alu_op)
            ALUOP_L'(ALU_ADD):  y = a + b;
            ALUOP_L'(ALU_SUB):  y = a - b;
            ALUOP_L'(ALU_SLT):  y = {{(REG_SZ-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUOP_L'(ALU_SLTU): y = {{(REG_SZ-1){1'b0}}, (a < b)};
            ALUOP_L'(ALU_XOR):  y = a ^ b;
            ALUOP_L'(ALU_OR):   y = a | b;
            ALUOP_L'(ALU_AND):  y = a & b;
            ALUOP_L'(ALU_SEQ):  y = {{(REG_SZ-1){1'b0}}, (a == b)};
`ifdef EX_BARREL_SHIFT_EN
            ALUOP_L'(ALU_SLL):  y = a << shamt;
            ALUOP_L'(ALU_SRL):  y = a >> shamt;
            ALUOP_L'(ALU_SRA):  y = $signed(a) >>> shamt;
`else
            // Shift-by-zero result; nonzero amounts are iterated by the parent
            ALUOP_L'(ALU_SLL), ALUOP_L'(ALU_SRL), ALUOP_L'(ALU_SRA): y = a;
`endif
            default:            valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ex.sv
// pipe_ex: execute stage between decode (up_syn/up_ack) and memory (down_syn/down_ack) stages.
// Macro EX_BARREL_SHIFT_EN selects single-cycle shifts; undefined, shifts take one cycle per bit.
module pipe_ex
    import pipe_ex_pkg::*;
#(
    parameter int REG_SZ  = 32,
    parameter int ALUOP_L = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_syn,
    output logic                     up_ack,
    output logic                     down_syn,
    input  logic                     down_ack,
    input  logic [6:0]               op,
    input  logic [2:0]               funct3,
    input  logic [ALUOP_L-1:0]       alu_op,
    input  logic [4:0]               rd_in,
    input  logic [REG_SZ-1:0]        pc,
    input  logic signed [REG_SZ-1:0] opr1,
    input  logic signed [REG_SZ-1:0] opr2,
    input  logic signed [REG_SZ-1:0] val,
    input  logic                     re_in,
    input  logic                     we_in,
    input  logic [1:0]               rlen_in,
    input  logic [1:0]               wlen_in,
    output logic [REG_SZ-1:0]        res,
    output logic [REG_SZ-1:0]        mem_addr,
    output logic [REG_SZ-1:0]        st_data,
    output logic                     br_taken,
    output logic [REG_SZ-1:0]        br_target,
    output logic [4:0]               rd,
    output logic                     re,
    output logic                     we,
    output logic [1:0]               rlen,
    output logic [1:0]               wlen,
    output logic                     ex_err
);

    ex_state_e          state;
    logic [6:0]         op_q;
    logic [2:0]         f3_q;
    logic [ALUOP_L-1:0] aop_q;
    logic [REG_SZ-1:0]  pc_q, a_q, b_q, v_q, sh_q, sh_next;
    logic               re_q, we_q;
    logic [4:0]         cnt_q;

    logic [REG_SZ-1:0]  alu_y, n_res, n_tgt;
    logic               alu_ok, n_taken, n_err, shift_start;

    ex_alu #(
        .REG_SZ  (REG_SZ),
        .ALUOP_L (ALUOP_L)
    ) u_alu (
        .alu_op (aop_q),
        .a      (a_q),
        .b      (b_q),
        .y      (alu_y),
        .valid  (alu_ok)
    );

    always_comb begin
        n_res   = '0;
        n_tgt   = '0;
        n_taken = 1'b0;
        n_err   = 1'b0;
        case (op_q)
            OP_LUI:   n_res = b_q;
            OP_AUIPC: n_res = pc_q + b_q;
            OP_JAL: begin
                n_res   = pc_q + REG_SZ'(4);
                n_taken = 1'b1;
                n_tgt   = pc_q + v_q;
            end
            OP_JALR: begin
                n_res   = pc_q + REG_SZ'(4);
                n_taken = 1'b1;
                n_tgt   = (a_q + b_q) & ~REG_SZ'(1);
            end
            OP_BRANCH: begin
                n_tgt = pc_q + v_q;
                case (f3_q)
                    F3_BEQ:  n_taken = (a_q == b_q);
                    F3_BNE:  n_taken = (a_q != b_q);
                    F3_BLT:  n_taken = ($signed(a_q) < $signed(b_q));
                    F3_BGE:  n_taken = ($signed(a_q) >= $signed(b_q));
                    F3_BLTU: n_taken = (a_q < b_q);
                    F3_BGEU: n_taken = (a_q >= b_q);
                    default: n_taken = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE, OP_MISC_MEM: n_res = '0;
            OP_OP, OP_OP_IMM: begin
                n_res = alu_y;
                n_err = ~alu_ok;
            end
            default: n_err = 1'b1;
        endcase
        if (n_err) begin
            n_res   = '0;
            n_tgt   = '0;
            n_taken = 1'b0;
        end
    end

`ifdef EX_BARREL_SHIFT_EN
    assign shift_start = 1'b0;
`else
    assign shift_start = ((op_q == OP_OP) || (op_q == OP_OP_IMM)) && is_shift_op(32'(aop_q))
                         && (b_q[4:0] != 5'd0);
`endif

    always_comb begin
        if (32'(aop_q) == ALU_SLL) begin
            sh_next = sh_q << 1;
        end else if (32'(aop_q) == ALU_SRL) begin
            sh_next = sh_q >> 1;
        end else begin
            sh_next = {sh_q[REG_SZ-1], sh_q[REG_SZ-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            up_ack    <= 1'b0;
            down_syn  <= 1'b0;
            res       <= '0;
            mem_addr  <= '0;
            st_data   <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
            rd        <= '0;
            re        <= 1'b0;
            we        <= 1'b0;
            rlen      <= '0;
            wlen      <= '0;
            ex_err    <= 1'b0;
            op_q      <= '0;
            f3_q      <= '0;
            aop_q     <= '0;
            pc_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            v_q       <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            sh_q      <= '0;
            cnt_q     <= '0;
        end else begin
            if (up_ack && !up_syn) up_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (up_syn && !up_ack) begin
                        op_q   <= op;
                        f3_q   <= funct3;
                        aop_q  <= alu_op;
                        pc_q   <= pc;
                        a_q    <= opr1;
                        b_q    <= opr2;
                        v_q    <= val;
                        re_q   <= re_in;
                        we_q   <= we_in;
                        rd     <= rd_in;
                        rlen   <= rlen_in;
                        wlen   <= wlen_in;
                        up_ack <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    ex_err    <= n_err;
                    br_taken  <= n_taken;
                    br_target <= n_tgt;
                    re        <= re_q & ~n_err;
                    we        <= we_q & ~n_err;
                    mem_addr  <= n_err ? '0 : a_q + b_q;
                    st_data   <= n_err ? '0 : v_q;
                    if (shift_start) begin
                        sh_q  <= a_q;
                        cnt_q <= b_q[4:0];
                        state <= SHIFT;
                    end else begin
                        res      <= n_res;
                        down_syn <= 1'b1;
                        state    <= DONE;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_next;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        res      <= sh_next;
                        down_syn <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (down_ack) begin
                        down_syn <= 1'b0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!down_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ex.sv
// Randomized self-checking bench for pipe_ex against a behavioural model of the execute rules.
module tb_pipe_ex;
    import pipe_ex_pkg::*;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  aop, rd;
        logic [31:0] pc, a, b, v;
        logic        re, we;
        logic [1:0]  rl, wl;
    } txn_t;

    typedef struct {
        logic [31:0] res, addr, sd, tgt;
        logic        taken, err, re, we;
        logic [4:0]  rd;
        logic [1:0]  rl, wl;
        bit          c_res, c_mem, c_tgt;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0, up_syn = 1'b0, down_ack = 1'b0;
    logic        up_ack, down_syn, br_taken, re, we, ex_err;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  alu_op = '0, rd_in = '0, rd;
    logic [31:0] pc = '0, opr1 = '0, opr2 = '0, val = '0;
    logic [31:0] res, mem_addr, st_data, br_target;
    logic        re_in = 1'b0, we_in = 1'b0;
    logic [1:0]  rlen_in = '0, wlen_in = '0, rlen, wlen;

    int          n_vec = 0, n_err = 0;
    bit          exp_valid = 1'b0;
    exp_t        cur;
    logic [31:0] got_res, got_tgt;
    logic        got_taken, got_err;
    int          got_lat;

    always #5 clk = ~clk;

    pipe_ex dut (
        .clk       (clk),
        .rst       (rst),
        .up_syn    (up_syn),
        .up_ack    (up_ack),
        .down_syn  (down_syn),
        .down_ack  (down_ack),
        .op        (op),
        .funct3    (funct3),
        .alu_op    (alu_op),
        .rd_in     (rd_in),
        .pc        (pc),
        .opr1      (opr1),
        .opr2      (opr2),
        .val       (val),
        .re_in     (re_in),
        .we_in     (we_in),
        .rlen_in   (rlen_in),
        .wlen_in   (wlen_in),
        .res       (res),
        .mem_addr  (mem_addr),
        .st_data   (st_data),
        .br_taken  (br_taken),
        .br_target (br_target),
        .rd        (rd),
        .re        (re),
        .we        (we),
        .rlen      (rlen),
        .wlen      (wlen),
        .ex_err    (ex_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    // Returns {valid, result}
    function automatic logic [32:0] alu_ref(input int unsigned code, input logic [31:0] a, b);
        logic [31:0] y = '0;
        logic        ok = 1'b1;
        case (code)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: y = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_SEQ:  y = (a == b) ? 32'd1 : 32'd0;
            default:  ok = 1'b0;
        endcase
        return {ok, y};
    endfunction

    function automatic logic branch_ref(input logic [2:0] f3, input logic [31:0] a, b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) < $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a < b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input txn_t t);
        exp_t        e;
        logic [32:0] r;
        int unsigned code = 32'(t.aop);
        e.res = '0; e.addr = t.a + t.b; e.sd = t.v; e.tgt = '0;
        e.taken = 1'b0; e.err = 1'b0; e.rd = t.rd; e.rl = t.rl; e.wl = t.wl;
        e.c_res = 1'b1; e.c_mem = 1'b0; e.c_tgt = 1'b0; e.lat = 1;
        case (t.op)
            OP_LUI:      e.res = t.b;
            OP_AUIPC:    e.res = t.pc + t.b;
            OP_JAL:      begin e.res = t.pc + 4; e.taken = 1'b1; e.tgt = t.pc + t.v; e.c_tgt = 1'b1; end
            OP_JALR: begin
                e.res = t.pc + 4; e.taken = 1'b1; e.c_tgt = 1'b1;
                e.tgt = (t.a + t.b) & 32'hFFFF_FFFE;
            end
            OP_BRANCH: begin
                e.c_res = 1'b0; e.c_tgt = 1'b1; e.tgt = t.pc + t.v;
                e.taken = branch_ref(t.f3, t.a, t.b);
            end
            OP_LOAD, OP_STORE: begin e.c_res = 1'b0; e.c_mem = 1'b1; end
            OP_MISC_MEM: e.res = '0;
            OP_OP, OP_OP_IMM: begin
                r = alu_ref(code, t.a, t.b);
                e.res = r[31:0];
                e.err = ~r[32];
`ifndef EX_BARREL_SHIFT_EN
                if ((code == ALU_SLL || code == ALU_SRL || code == ALU_SRA) && t.b[4:0] != 5'd0)
                    e.lat = 1 + int'(t.b[4:0]);
`endif
            end
            default: e.err = 1'b1;
        endcase
        if (e.err) begin
            e.res = '0; e.taken = 1'b0; e.c_res = 1'b1; e.c_tgt = 1'b0; e.c_mem = 1'b0;
        end
        e.re = t.re & ~e.err;
        e.we = t.we & ~e.err;
        return e;
    endfunction

    function automatic txn_t mk(input logic [6:0] o, input logic [2:0] f, input int unsigned aop,
                                input logic [31:0] p, a, b, v);
        txn_t t;
        t.op = o; t.f3 = f; t.aop = 5'(aop); t.rd = 5'd7; t.pc = p; t.a = a; t.b = b; t.v = v;
        t.re = 1'b0; t.we = 1'b0; t.rl = 2'd2; t.wl = 2'd1;
        return t;
    endfunction

    function automatic txn_t rnd();
        txn_t t;
        case ($urandom_range(0, 10))
            0:  t.op = OP_LUI;
            1:  t.op = OP_AUIPC;
            2:  t.op = OP_JAL;
            3:  t.op = OP_JALR;
            4:  t.op = OP_BRANCH;
            5:  t.op = OP_LOAD;
            6:  t.op = OP_STORE;
            7:  t.op = OP_OP;
            8:  t.op = OP_OP_IMM;
            9:  t.op = OP_MISC_MEM;
            default: t.op = 7'($urandom);
        endcase
        t.f3 = 3'($urandom); t.aop = 5'($urandom_range(0, 12)); t.rd = 5'($urandom);
        t.pc = $urandom; t.a = $urandom; t.b = $urandom; t.v = $urandom;
        t.re = 1'($urandom); t.we = 1'($urandom); t.rl = 2'($urandom); t.wl = 2'($urandom);
        if ($urandom_range(0, 3) == 0) t.b[4:0] = ($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0;
        if ($urandom_range(0, 4) == 0) t.b = t.a;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        op = t.op; funct3 = t.f3; alu_op = t.aop; rd_in = t.rd; pc = t.pc;
        opr1 = t.a; opr2 = t.b; val = t.v; re_in = t.re; we_in = t.we;
        rlen_in = t.rl; wlen_in = t.wl;
    endtask

    task automatic wait_accept(input txn_t t);
        int k = 0;
        drive(t);
        up_syn = 1'b1;
        do begin @(posedge clk); #1; k++; end while (!up_ack && k < 20);
        chk("accept", 32'(up_ack), 32'd1);
        cur = model(t);
        exp_valid = 1'b1;
        up_syn = 1'b0;
    endtask

    task automatic run(input txn_t t, input int hold, input bit poke);
        int k = 0;
        wait_accept(t);
        do begin @(posedge clk); #1; k++; end while (!down_syn && k < 64);
        got_lat = k; got_res = res; got_tgt = br_target; got_taken = br_taken; got_err = ex_err;
        chk("latency", 32'(k), 32'(cur.lat));
        for (int i = 0; i < hold; i++) begin
            if (poke) up_syn = 1'b1;
            @(posedge clk); #1;
            if (poke) chk("ack_while_busy", 32'(up_ack), 32'd0);
        end
        up_syn = 1'b0;
        down_ack = 1'b1;
        @(posedge clk); #1;
        chk("down_syn_clear", 32'(down_syn), 32'd0);
        exp_valid = 1'b0;
        down_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, 32'({up_ack, down_syn, br_taken, re, we, ex_err, rd, rlen, wlen}), 32'd0);
        chk({tag, "_res"}, res, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_st_data"}, st_data, 32'd0);
        chk({tag, "_br_target"}, br_target, 32'd0);
    endtask

    // Checks every cycle the result is presented, which also covers stability while held
    always @(negedge clk) begin
        if (rst && down_syn) begin
            if (!exp_valid) begin
                chk("spurious_down_syn", 32'(down_syn), 32'd0);
            end else begin
                chk("ex_err", 32'(ex_err), 32'(cur.err));
                chk("br_taken", 32'(br_taken), 32'(cur.taken));
                chk("re", 32'(re), 32'(cur.re));
                chk("we", 32'(we), 32'(cur.we));
                chk("rd", 32'(rd), 32'(cur.rd));
                chk("rlen", 32'(rlen), 32'(cur.rl));
                chk("wlen", 32'(wlen), 32'(cur.wl));
                if (cur.c_res) chk("res", res, cur.res);
                if (cur.c_tgt) chk("br_target", br_target, cur.tgt);
                if (cur.c_mem) begin
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("st_data", st_data, cur.sd);
                end
            end
        end
    end

    initial begin
        txn_t t;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        run(mk(OP_OP, 3'd0, ALU_ADD, 32'h0, 32'd5, 32'hFFFF_FFF9, 32'h0), 0, 1'b0);
        chk("add_res_lit", got_res, 32'hFFFF_FFFE);
        chk("add_lat_lit", 32'(got_lat), 32'd1);

        run(mk(OP_BRANCH, F3_BLTU, 0, 32'h100, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8), 1, 1'b0);
        chk("bltu_taken_lit", 32'(got_taken), 32'd1);
        chk("bltu_tgt_lit", got_tgt, 32'h0000_00F8);
        run(mk(OP_BRANCH, F3_BLT, 0, 32'h100, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8), 0, 1'b0);
        chk("blt_taken_lit", 32'(got_taken), 32'd0);

        run(mk(OP_OP, 3'd0, ALU_SRA, 32'h0, 32'h8000_0000, 32'd4, 32'h0), 0, 1'b0);
        chk("sra_res_lit", got_res, 32'hF800_0000);
`ifdef EX_BARREL_SHIFT_EN
        chk("sra_lat_lit", 32'(got_lat), 32'd1);
`else
        chk("sra_lat_lit", 32'(got_lat), 32'd5);
`endif

        run(mk(OP_JALR, 3'd0, 0, 32'h40, 32'h1003, 32'd2, 32'h0), 0, 1'b0);
        chk("jalr_tgt_lit", got_tgt, 32'h0000_1004);
        chk("jalr_res_lit", got_res, 32'h0000_0044);

        run(mk(7'b1111111, 3'd0, 0, 32'h40, 32'h1, 32'h2, 32'h3), 0, 1'b0);
        chk("bad_op_err_lit", 32'(got_err), 32'd1);
        run(mk(OP_OP, 3'd0, 15, 32'h40, 32'h1, 32'h2, 32'h3), 0, 1'b0);
        chk("bad_aluop_err_lit", 32'(got_err), 32'd1);

        // Memory stage stalls for 10 cycles while decode keeps requesting
        run(mk(OP_AUIPC, 3'd0, 0, 32'h1000, 32'h0, 32'h2345, 32'h0), 10, 1'b1);

        for (int i = 0; i < 150; i++) run(rnd(), int'($urandom_range(0, 3)), 1'b0);

        // Reset in the middle of a long shift discards it
        t = mk(OP_OP_IMM, 3'd0, ALU_SLL, 32'h0, 32'h1, 32'd10, 32'h0);
        wait_accept(t);
        repeat (3) @(posedge clk);
        #1;
        exp_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset("reset_mid_op");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run(mk(OP_OP, 3'd0, ALU_SUB, 32'h0, 32'd3, 32'd10, 32'h0), 0, 1'b0);
        chk("after_reset_res_lit", got_res, 32'hFFFF_FFF9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ex.md
PIPE_EX -- requirements
Module: pipe_ex

Interface
REQ-001 SHALL have parameter REG_SZ, default 32, datapath width.
REQ-002 SHALL have parameter ALUOP_L, default 5, alu_op width.
REQ-003 SHALL have one clock, clk; reset rst is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- up_syn  in  1  request from decode stage
- up_ack  out  1  accept acknowledge to decode stage
- down_syn  out  1  result valid to memory stage
- down_ack  in  1  acknowledge from memory stage
- op  in  7  major opcode
- funct3  in  3  branch/mem subtype
- alu_op  in  ALUOP_L  ALU operation
- rd_in  in  5  destination register
- pc  in  REG_SZ  instruction address
- opr1, opr2, val  in  REG_SZ  signed operands from decode
- re_in, we_in  in  1  load/store enables
- rlen_in, wlen_in  in  2  access length codes
- res  out  REG_SZ  ALU/link result
- mem_addr  out  REG_SZ  load/store address
- st_data  out  REG_SZ  store data
- br_taken  out  1  redirect PC
- br_target  out  REG_SZ  redirect address
- rd, re, we, rlen, wlen  out  5/1/1/2/2  registered pass-through
- ex_err  out  1  unknown op/alu_op

Function
REQ-005 SHALL use FSM states IDLE, EXEC, SHIFT, DONE, RELEASE.
REQ-006 SHALL accept in IDLE when up_syn=1 and up_ack=0: register all inputs, set up_ack=1, go to EXEC.
REQ-007 SHALL hold up_ack=1 until up_syn is sampled 0, then clear up_ack on that edge.
REQ-008 SHALL ignore up_syn in every state other than IDLE.
REQ-009 SHALL, in EXEC, register all outputs and set down_syn=1 at the next edge (latency: accept edge N, down_syn high after edge N+1), going to DONE; shift ops go to SHIFT per REQ-018.
REQ-010 SHALL compute results by op:
- LUI: res=opr2
- AUIPC: res=pc+opr2
- JAL: res=pc+4, br_taken=1, br_target=pc+val
- JALR: res=pc+4, br_taken=1, br_target=(opr1+opr2) with bit0 cleared
- BRANCH: br_target=pc+val; br_taken per funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU) from opr1 vs opr2
- LOAD/STORE: mem_addr=opr1+opr2, st_data=val
- OP/OP_IMM: res=ALU(alu_op, opr1, opr2)
- MISC_MEM: res=0, no side effects
REQ-011 SHALL wrap all arithmetic modulo 2^REG_SZ; SLT is signed, SLTU unsigned, SEQ yields 1/0; shift amount is opr2[4:0].
REQ-012 SHALL drive br_taken=0 for every op other than JAL, JALR and taken branches.
REQ-013 SHALL, for an unknown op or alu_op, set ex_err=1, res=0, re=we=0, br_taken=0, and still complete the handshake.
REQ-014 SHALL hold down_syn=1 and all outputs stable in DONE until down_ack is sampled 1, then clear down_syn and go to RELEASE.
REQ-015 SHALL return from RELEASE to IDLE when down_ack is sampled 0; outputs hold their values.
REQ-016 SHALL permit a new acceptance on the same edge that RELEASE exits to IDLE only from the following cycle.

Reset
REQ-017 SHALL, while rst=0, force state=IDLE and drive up_ack, down_syn, br_taken, re, we and ex_err to 0; res, mem_addr, st_data, br_target, rd, rlen, wlen to 0; reset mid-operation discards the instruction.

Configuration
REQ-018 SHALL honour macro EX_BARREL_SHIFT_EN:
- Defined: SLL/SRL/SRA complete in EXEC (latency as REQ-009).
- Undefined: shifts iterate one bit per cycle in SHIFT for shamt cycles, then set down_syn; shamt=0 takes EXEC path with no SHIFT cycle; SRA replicates the sign bit.

Structure
REQ-019 SHALL take op, funct3 and ALU_* codes from the shared riscv_const/alu_opcode constant headers; FSM state encodings belong in the same shared package.
REQ-020 SHALL place the combinational ALU in sub-module ex_alu.

Verification
REQ-021 ADD: opr1=5, opr2=-7 -> res=0xFFFFFFFE, down_syn high one cycle after accept.
REQ-022 BLTU: opr1=1, opr2=0xFFFFFFFF, pc=0x100, val=-8 -> br_taken=1, br_target=0xF8; BLT on the same operands -> br_taken=0.
REQ-023 SRA: opr1=0x80000000, shamt=4 -> res=0xF8000000; macro off: down_syn after 1+4 cycles; macro on: after 1.
REQ-024 Hold down_ack=0 for 10 cycles -> outputs stable and a new up_syn is not acked; then down_ack=1 -> down_syn=0 next edge.
REQ-025 Assert rst=0 during SHIFT -> all outputs reach reset values immediately; next up_syn is accepted normally.
REQ-026 JALR: opr1=0x1003, opr2=2, pc=0x40 -> br_target=0x1004, res=0x44.
